// File: rtl/fpu_req_scheduler.sv
// Shares one FPU pipeline among NUM_REQS requesters: round-robin grant, tag free list,
// owner table for out-of-order response routing, and a flush/drain sequencer.

module fpu_req_scheduler_cnt #(
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt
);
  // A same-cycle issue and release for this requester cancel out.
  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (inc && !dec)   cnt <= cnt + 1'b1;
    else if (dec && !inc)   cnt <= cnt - 1'b1;
  end
endmodule

module fpu_req_scheduler #(
  parameter int NUM_REQS  = 4,
  parameter int DATAW     = 64,
  parameter int QSIZE     = 8,
  parameter int TAG_WIDTH = $clog2(QSIZE),
  parameter int REQ_IDXW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int CNTW      = $clog2(QSIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      fpu_req_valid,
  output logic [DATAW-1:0]          fpu_req_data,
  output logic [TAG_WIDTH-1:0]      fpu_req_tag,
  input  logic                      fpu_req_ready,
  input  logic                      fpu_rsp_valid,
  input  logic [TAG_WIDTH-1:0]      fpu_rsp_tag,
  output logic                      fpu_rsp_ready,
  output logic                      rsp_valid,
  output logic [REQ_IDXW-1:0]       rsp_req_idx,
  input  logic                      rsp_ready,
  output logic [NUM_REQS*CNTW-1:0]  outstanding,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                        state;
  logic [QSIZE-1:0]                  inuse;
  logic [QSIZE-1:0][REQ_IDXW-1:0]    owner;
  logic [REQ_IDXW-1:0]               rr_ptr, grant, rsp_owner;
  logic [TAG_WIDTH-1:0]              free_tag;
  logic [QSIZE-1:0]                  alloc_mask, rel_mask;
  logic [NUM_REQS-1:0][CNTW-1:0]     cnt;
  logic                              can_issue, req_fire, rsp_fire;

  // Rotating priority: scan downward so the requester closest to rr_ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = rr_ptr;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (req_valid[idx]) grant = REQ_IDXW'(idx);
    end
  end

  always_comb begin
    free_tag = '0;
    for (int t = QSIZE - 1; t >= 0; t--)
      if (!inuse[t]) free_tag = TAG_WIDTH'(t);
  end

  assign can_issue     = !reset && (state == RUN) && !flush && !(&inuse);
  assign fpu_req_valid = can_issue && (|req_valid);
  assign fpu_req_data  = reset ? '0 : req_data[int'(grant)*DATAW +: DATAW];
  assign fpu_req_tag   = reset ? '0 : free_tag;
  assign req_fire      = fpu_req_valid && fpu_req_ready;

  always_comb begin
    req_ready        = '0;
    req_ready[grant] = can_issue && fpu_req_ready;
  end

  assign rsp_owner     = owner[fpu_rsp_tag];
  assign rsp_valid     = !reset && fpu_rsp_valid;
  assign rsp_req_idx   = reset ? '0 : rsp_owner;
  assign fpu_rsp_ready = rsp_ready;
  // Releases of tags not in use are ignored so bookkeeping stays consistent.
  assign rsp_fire      = !reset && fpu_rsp_valid && rsp_ready && inuse[fpu_rsp_tag];

  assign alloc_mask = req_fire ? (QSIZE'(1) << free_tag)    : '0;
  assign rel_mask   = rsp_fire ? (QSIZE'(1) << fpu_rsp_tag) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      inuse  <= '0;
      rr_ptr <= '0;
      state  <= RUN;
    end else begin
      inuse <= (inuse & ~rel_mask) | alloc_mask;
      if (req_fire)
        rr_ptr <= (int'(grant) == NUM_REQS - 1) ? '0 : grant + 1'b1;
      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (inuse == '0) state <= DONE;
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) owner[free_tag] <= grant;
  end

  always_ff @(posedge clk) begin
    if (!reset && fpu_rsp_valid && rsp_ready)
      assert (inuse[fpu_rsp_tag]) else $error("response to idle tag %0d", fpu_rsp_tag);
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
    fpu_req_scheduler_cnt #(.CNTW(CNTW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (req_fire && (grant == REQ_IDXW'(i))),
      .dec   (rsp_fire && (rsp_owner == REQ_IDXW'(i))),
      .cnt   (cnt[i])
    );
    assign outstanding[i*CNTW +: CNTW] = reset ? '0 : cnt[i];
  end

  assign busy       = !reset && (|inuse);
  assign flush_done = !reset && (state == DONE);
endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Directed bench for fpu_req_scheduler: issue/release, round-robin, full queue,
// same-cycle issue+release, flush drain and mid-flight reset.
module tb_fpu_req_scheduler;
  localparam int NR = 4, DW = 64, QS = 8, TW = 3, RW = 2, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             fpu_req_valid, fpu_req_ready;
  logic [DW-1:0]    fpu_req_data;
  logic [TW-1:0]    fpu_req_tag, fpu_rsp_tag;
  logic             fpu_rsp_valid, fpu_rsp_ready, rsp_valid, rsp_ready;
  logic [RW-1:0]    rsp_req_idx;
  logic [NR*CW-1:0] outstanding;
  logic             flush, flush_done, busy;

  int n_cmp = 0, n_err = 0;

  fpu_req_scheduler #(.NUM_REQS(NR), .DATAW(DW), .QSIZE(QS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fpu_req_valid(fpu_req_valid), .fpu_req_data(fpu_req_data),
    .fpu_req_tag(fpu_req_tag), .fpu_req_ready(fpu_req_ready),
    .fpu_rsp_valid(fpu_rsp_valid), .fpu_rsp_tag(fpu_rsp_tag),
    .fpu_rsp_ready(fpu_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_req_idx(rsp_req_idx), .rsp_ready(rsp_ready),
    .outstanding(outstanding), .flush(flush), .flush_done(flush_done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] outs(input int i);
    return outstanding[i*CW +: CW];
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; fpu_req_ready = 1'b0;
    fpu_rsp_valid = 1'b0; fpu_rsp_tag = '0; rsp_ready = 1'b1; flush = 1'b0;
    tick; tick;
    #1;
    chk("rst_req_valid", fpu_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_rsp_ready", fpu_rsp_ready, 1);
    reset = 1'b0;
    tick;
    #1;
    chk("post_rst_outstanding", outstanding, 0);
    chk("post_rst_tag", fpu_req_tag, 0);

    // single requester, three issues, out-of-order returns
    req_valid = 4'b0001; req_data[0 +: DW] = 64'hA0; fpu_req_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t1_tag", fpu_req_tag, j);
      chk("t1_ready", req_ready, 4'b0001);
      chk("t1_data", fpu_req_data, 64'hA0);
      tick;
    end
    req_valid = '0;
    #1;
    chk("t1_out3", outs(0), 3);
    chk("t1_busy", busy, 1);
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd2;
    #1;
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_idx_t2", rsp_req_idx, 0);
    tick;
    fpu_rsp_tag = 3'd0;
    #1;
    chk("t1_out2", outs(0), 2);
    chk("t1_idx_t0", rsp_req_idx, 0);
    tick;
    fpu_rsp_tag = 3'd1;
    #1;
    chk("t1_idx_t1", rsp_req_idx, 0);
    chk("t1_busy_last", busy, 1);
    tick;
    fpu_rsp_valid = 1'b0;
    #1;
    chk("t1_busy_drop", busy, 0);
    chk("t1_out0", outs(0), 0);

    // all four requesters, response every cycle; rr_ptr is now 1
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 64'h100 + i;
    for (int k = 0; k < 8; k++) begin
      fpu_rsp_valid = (k > 0);
      fpu_rsp_tag   = (k > 0) ? TW'((k - 1) % 2) : '0;
      #1;
      chk("rr_grant", req_ready, 4'b0001 << ((k + 1) % 4));
      chk("rr_tag", fpu_req_tag, k % 2);
      chk("rr_data", fpu_req_data, 64'h100 + (k + 1) % 4);
      if (k > 0) chk("rr_owner", rsp_req_idx, k % 4);
      tick;
    end
    req_valid = '0; fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd1;
    #1;
    chk("rr_last_owner", rsp_req_idx, 0);
    tick;
    fpu_rsp_valid = 1'b0;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_out", outstanding, 0);

    // fill all tags, then free tag 5 and see it reissued
    req_valid = 4'b0001;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("full_tag", fpu_req_tag, j);
      tick;
    end
    #1;
    chk("full_valid", fpu_req_valid, 0);
    chk("full_ready", req_ready, 0);
    chk("full_out", outs(0), 8);
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd5;
    #1;
    chk("full_valid_rel", fpu_req_valid, 0);
    tick;
    fpu_rsp_valid = 1'b0;
    #1;
    chk("reissue_valid", fpu_req_valid, 1);
    chk("reissue_tag", fpu_req_tag, 5);
    chk("reissue_out", outs(0), 7);
    tick;
    req_valid = '0;
    #1;
    chk("refill_out", outs(0), 8);
    for (int j = 0; j < 8; j++) begin
      fpu_rsp_valid = 1'b1; fpu_rsp_tag = TW'(j);
      tick;
    end
    fpu_rsp_valid = 1'b0;
    #1;
    chk("full_drained", busy, 0);

    // same-cycle issue and release for requester 1; rr_ptr is 1
    req_valid = 4'b0010;
    #1;
    chk("same_grant", req_ready, 4'b0010);
    chk("same_tag0", fpu_req_tag, 0);
    tick;
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd0;
    #1;
    chk("same_no_reuse", fpu_req_tag, 1);
    chk("same_owner", rsp_req_idx, 1);
    tick;
    req_valid = '0; fpu_rsp_valid = 1'b0;
    #1;
    chk("same_out1", outs(1), 1);
    chk("same_free0", fpu_req_tag, 0);
    fpu_rsp_valid = 1'b1; fpu_rsp_tag = 3'd1;
    tick;
    fpu_rsp_valid = 1'b0;
    #1;
    chk("same_idle", busy, 0);

    // flush with three tags in flight
    req_valid = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("fl_tag", fpu_req_tag, j);
      tick;
    end
    flush = 1'b1;
    #1;
    chk("fl_block", fpu_req_valid, 0);
    chk("fl_block_ready", req_ready, 0);
    tick;
    for (int d = 0; d < 10; d++) begin
      fpu_rsp_valid = (d == 2) || (d == 5) || (d == 8);
      fpu_rsp_tag   = (d == 2) ? 3'd0 : (d == 5) ? 3'd1 : 3'd2;
      #1;
      chk("fl_no_done", flush_done, 0);
      chk("fl_no_grant", fpu_req_valid, 0);
      if (d == 2) chk("fl_route", rsp_req_idx, 0);
      if (d == 9) chk("fl_idle", busy, 0);
      tick;
    end
    #1;
    chk("fl_done", flush_done, 1);
    flush = 1'b0;
    tick;
    #1;
    chk("fl_done_pulse", flush_done, 0);
    chk("fl_resume", fpu_req_valid, 1);
    chk("fl_resume_tag", fpu_req_tag, 0);

    // reset with five tags in flight
    for (int j = 0; j < 5; j++) tick;
    #1;
    chk("rst5_out", outs(0), 5);
    req_valid = 4'b1111; reset = 1'b1;
    #1;
    chk("rst5_valid", fpu_req_valid, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("rst5_busy", busy, 0);
    chk("rst5_outs", outstanding, 0);
    chk("rst5_tag", fpu_req_tag, 0);
    chk("rst5_grant", req_ready, 4'b0001);
    chk("rst5_data", fpu_req_data, 64'h100);
    tick;
    req_valid = '0;
    #1;
    chk("rst5_out_after", outs(0), 1);
    chk("rst5_busy_after", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
